// File: rtl/trace_capture_fifo.sv
// trace_capture_fifo
//   Captures the datapath observation triple {instruction, read1, read2} into
//   a circular FIFO. Drains it to a debug host as three 32-bit words per entry
//   over a valid/ready stream. The core is never stalled. A sample that arrives
//   while the FIFO is full is dropped, and a sticky overflow flag is raised.
//
// Ports
//   clock           rising-edge clock
//   reset_n         asynchronous active-low reset
//   iEnable         capture a sample this cycle
//   iInstruction    instruction word (streamed first)
//   iRegisterRead1  register read port 1 (streamed second)
//   iRegisterRead2  register read port 2 (streamed third)
//   iClearOverflow  synchronous clear of oOverflow (a same-cycle drop wins)
//   oData           current stream word (registered)
//   oValid          oData is valid
//   iReady          host accepts oData when oValid && iReady
//   oCount          entries held, including the one being drained
//   oOverflow       sticky: a sample was dropped because the FIFO was full
module trace_capture_fifo #(
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              clock,
  input  logic              reset_n,
  input  logic              iEnable,
  input  logic [31:0]       iInstruction,
  input  logic [31:0]       iRegisterRead1,
  input  logic [31:0]       iRegisterRead2,
  input  logic              iClearOverflow,
  output logic [31:0]       oData,
  output logic              oValid,
  input  logic              iReady,
  output logic [ADDR_W:0]   oCount,
  output logic              oOverflow
);

  localparam logic [ADDR_W:0]   FULL_COUNT = (ADDR_W+1)'(DEPTH);
  localparam logic [ADDR_W:0]   COUNT_ONE  = (ADDR_W+1)'(1);
  localparam logic [ADDR_W-1:0] PTR_ONE    = ADDR_W'(1);

  typedef enum logic [1:0] {IDLE, W0, W1, W2} drainState_t;

  drainState_t       state;
  drainState_t       stateNext;

  logic [95:0]       entryMem [DEPTH];
  logic [95:0]       nextEntry;
  logic [ADDR_W-1:0] wrPtr;
  logic [ADDR_W-1:0] rdPtr;
  logic [ADDR_W-1:0] rdPtrNext;
  logic [ADDR_W:0]   countNext;
  logic [31:0]       dataNext;
  logic              handshake;
  logic              push;
  logic              pop;
  logic              drop;

  // Push/pop decisions. A full FIFO still accepts a sample in the cycle the
  // last word of the head entry is handed off.
  always_comb begin
    handshake = oValid && iReady;
    pop       = handshake && (state == W2);
    push      = iEnable && ((oCount < FULL_COUNT) || pop);
    drop      = iEnable && !push;
    rdPtrNext = pop ? (rdPtr + PTR_ONE) : rdPtr;
    countNext = oCount;
    if (push && !pop) begin
      countNext = oCount + COUNT_ONE;
    end else if (!push && pop) begin
      countNext = oCount - COUNT_ONE;
    end
  end

  // Drain FSM: IDLE costs one bubble cycle before the first word. After that,
  // entries stream back to back as long as the FIFO stays non-empty.
  always_comb begin
    stateNext = state;
    case (state)
      IDLE: if (oCount != '0) stateNext = W0;
      W0:   if (handshake) stateNext = W1;
      W1:   if (handshake) stateNext = W2;
      W2:   if (handshake) stateNext = (countNext != '0) ? W0 : IDLE;
      default: stateNext = IDLE;
    endcase
  end

  // oData is registered, so the next word is chosen from the next state and
  // the next read pointer. When the FIFO drains down to exactly the sample
  // being written this cycle, that sample is not in the array yet. It is
  // forwarded straight from the inputs.
  always_comb begin
    if (push && (wrPtr == rdPtrNext)) begin
      nextEntry = {iInstruction, iRegisterRead1, iRegisterRead2};
    end else begin
      nextEntry = entryMem[rdPtrNext];
    end
    case (stateNext)
      W0:      dataNext = nextEntry[95:64];
      W1:      dataNext = nextEntry[63:32];
      W2:      dataNext = nextEntry[31:0];
      default: dataNext = '0;
    endcase
  end

  always_ff @(posedge clock) begin
    if (push) begin
      entryMem[wrPtr] <= {iInstruction, iRegisterRead1, iRegisterRead2};
    end
  end

  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state     <= IDLE;
      wrPtr     <= '0;
      rdPtr     <= '0;
      oCount    <= '0;
      oValid    <= 1'b0;
      oData     <= '0;
      oOverflow <= 1'b0;
    end else begin
      state  <= stateNext;
      rdPtr  <= rdPtrNext;
      oCount <= countNext;
      oValid <= (stateNext != IDLE);
      oData  <= dataNext;
      if (push) begin
        wrPtr <= wrPtr + PTR_ONE;
      end
      if (drop) begin
        oOverflow <= 1'b1;
      end else if (iClearOverflow) begin
        oOverflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_trace_capture_fifo.sv
// tb_trace_capture_fifo
//   Directed bench for trace_capture_fifo (DEPTH 16). It covers reset, a single
//   entry, backpressure, forwarding into W0, overflow and clear, full with a
//   simultaneous pop, a long wrapping stream and an asynchronous reset mid-drain.
module tb_trace_capture_fifo;

  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic              clock;
  logic              reset_n;
  logic              iEnable;
  logic [31:0]       iInstruction;
  logic [31:0]       iRegisterRead1;
  logic [31:0]       iRegisterRead2;
  logic              iClearOverflow;
  logic [31:0]       oData;
  logic              oValid;
  logic              iReady;
  logic [ADDR_W:0]   oCount;
  logic              oOverflow;

  int numAsserts = 0;
  int numFails   = 0;

  logic [31:0] expWords [120];

  trace_capture_fifo #(.DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .clock          (clock),
    .reset_n        (reset_n),
    .iEnable        (iEnable),
    .iInstruction   (iInstruction),
    .iRegisterRead1 (iRegisterRead1),
    .iRegisterRead2 (iRegisterRead2),
    .iClearOverflow (iClearOverflow),
    .oData          (oData),
    .oValid         (oValid),
    .iReady         (iReady),
    .oCount         (oCount),
    .oOverflow      (oOverflow)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  task automatic checkEq(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    numAsserts++;
    if (actual !== expected) begin
      numFails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  // Advance one rising edge; outputs are sampled and inputs driven 2 ns later.
  task automatic stepCycle();
    @(posedge clock);
    #2;
  endtask

  task automatic driveSample(input logic [31:0] a, input logic [31:0] b, input logic [31:0] c);
    iInstruction   = a;
    iRegisterRead1 = b;
    iRegisterRead2 = c;
  endtask

  task automatic checkIdle(input string tag);
    checkEq({tag, "_valid"}, 32'(oValid), 32'd0);
    checkEq({tag, "_count"}, 32'(oCount), 32'd0);
  endtask

  initial begin
    int gotWords;
    int pushed;
    bit started;

    reset_n        = 1'b0;
    iEnable        = 1'b0;
    iClearOverflow = 1'b0;
    iReady         = 1'b0;
    driveSample(32'h0, 32'h0, 32'h0);
    stepCycle();
    stepCycle();

    // Reset state
    checkEq("rst_valid",    32'(oValid),    32'd0);
    checkEq("rst_count",    32'(oCount),    32'd0);
    checkEq("rst_overflow", 32'(oOverflow), 32'd0);
    checkEq("rst_data",     oData,          32'h0);
    reset_n = 1'b1;
    stepCycle();

    // Single entry at full rate
    iReady = 1'b1;
    driveSample(32'h00500093, 32'h1, 32'h2);
    iEnable = 1'b1;
    stepCycle();
    iEnable = 1'b0;
    checkEq("single_bubble_valid", 32'(oValid), 32'd0);
    checkEq("single_bubble_count", 32'(oCount), 32'd1);
    stepCycle();
    checkEq("single_w0_valid", 32'(oValid), 32'd1);
    checkEq("single_w0_data",  oData, 32'h00500093);
    stepCycle();
    checkEq("single_w1_data",  oData, 32'h1);
    stepCycle();
    checkEq("single_w2_data",  oData, 32'h2);
    checkEq("single_w2_count", 32'(oCount), 32'd1);
    stepCycle();
    checkIdle("single_done");

    // Backpressure in W1, then a sample pushed on the W2 pop of the last entry
    driveSample(32'hAAAA0001, 32'hBBBB0001, 32'hCCCC0001);
    iEnable = 1'b1;
    stepCycle();
    iEnable = 1'b0;
    stepCycle();
    checkEq("bp_w0_data", oData, 32'hAAAA0001);
    stepCycle();
    iReady = 1'b0;
    for (int k = 0; k < 5; k++) begin
      checkEq("bp_hold_valid", 32'(oValid), 32'd1);
      checkEq("bp_hold_data",  oData, 32'hBBBB0001);
      stepCycle();
    end
    iReady = 1'b1;
    stepCycle();
    checkEq("bp_resume_w2", oData, 32'hCCCC0001);
    driveSample(32'hDDDD0002, 32'hEEEE0002, 32'hFFFF0002);
    iEnable = 1'b1;
    stepCycle();
    iEnable = 1'b0;
    checkEq("fwd_w0_valid", 32'(oValid), 32'd1);
    checkEq("fwd_w0_data",  oData, 32'hDDDD0002);
    checkEq("fwd_count",    32'(oCount), 32'd1);
    stepCycle();
    checkEq("fwd_w1_data",  oData, 32'hEEEE0002);
    stepCycle();
    checkEq("fwd_w2_data",  oData, 32'hFFFF0002);
    stepCycle();
    checkIdle("fwd_done");

    // Overflow: the host is stalled and DEPTH+2 samples are offered
    iReady = 1'b0;
    for (int i = 0; i < DEPTH + 2; i++) begin
      driveSample(32'h1000 + 32'(i), 32'h2000 + 32'(i), 32'h3000 + 32'(i));
      iEnable = 1'b1;
      stepCycle();
    end
    iEnable = 1'b0;
    checkEq("ovf_count",    32'(oCount),    32'd16);
    checkEq("ovf_flag",     32'(oOverflow), 32'd1);
    checkEq("ovf_w0_data",  oData,          32'h1000);
    iEnable = 1'b1;
    iClearOverflow = 1'b1;
    stepCycle();
    iEnable = 1'b0;
    checkEq("ovf_drop_wins", 32'(oOverflow), 32'd1);
    stepCycle();
    iClearOverflow = 1'b0;
    checkEq("ovf_cleared",   32'(oOverflow), 32'd0);
    checkEq("ovf_count_kept", 32'(oCount),   32'd16);

    // Full with a simultaneous pop
    iReady = 1'b1;
    stepCycle();
    checkEq("full_w1_data", oData, 32'h2000);
    stepCycle();
    checkEq("full_w2_data", oData, 32'h3000);
    checkEq("full_w2_count", 32'(oCount), 32'd16);
    driveSample(32'hA0A0A0A0, 32'hB0B0B0B0, 32'hC0C0C0C0);
    iEnable = 1'b1;
    stepCycle();
    iEnable = 1'b0;
    checkEq("full_pop_count",    32'(oCount),    32'd16);
    checkEq("full_pop_overflow", 32'(oOverflow), 32'd0);
    for (int e = 0; e < 15; e++) begin
      expWords[3*e]     = 32'h1001 + 32'(e);
      expWords[3*e + 1] = 32'h2001 + 32'(e);
      expWords[3*e + 2] = 32'h3001 + 32'(e);
    end
    expWords[45] = 32'hA0A0A0A0;
    expWords[46] = 32'hB0B0B0B0;
    expWords[47] = 32'hC0C0C0C0;
    for (int w = 0; w < 48; w++) begin
      checkEq("full_drain_valid", 32'(oValid), 32'd1);
      checkEq("full_drain_data",  oData, expWords[w]);
      stepCycle();
    end
    checkIdle("full_drain_done");

    // Wrap: 40 entries, the host always ready, 2 captures per 5 cycles
    for (int e = 0; e < 40; e++) begin
      expWords[3*e]     = 32'h70000000 + 32'(e);
      expWords[3*e + 1] = 32'h51000000 + 32'(e);
      expWords[3*e + 2] = 32'h52000000 + 32'(e);
    end
    gotWords = 0;
    pushed   = 0;
    started  = 1'b0;
    for (int c = 0; c < 200; c++) begin
      if (oValid) begin
        started = 1'b1;
        if (gotWords < 120) begin
          checkEq("wrap_word", oData, expWords[gotWords]);
        end
        gotWords++;
      end else if (started && gotWords < 120) begin
        checkEq("wrap_no_bubble", 32'(oValid), 32'd1);
      end
      if (pushed < 40 && (c % 5 == 0 || c % 5 == 2)) begin
        driveSample(32'h70000000 + 32'(pushed), 32'h51000000 + 32'(pushed),
                    32'h52000000 + 32'(pushed));
        iEnable = 1'b1;
        pushed++;
      end else begin
        iEnable = 1'b0;
      end
      stepCycle();
    end
    iEnable = 1'b0;
    checkEq("wrap_word_total", 32'(gotWords),  32'd120);
    checkEq("wrap_count",      32'(oCount),    32'd0);
    checkEq("wrap_overflow",   32'(oOverflow), 32'd0);

    // Asynchronous reset mid-W1 with three entries held
    iReady = 1'b0;
    for (int i = 0; i < 3; i++) begin
      driveSample(32'h4000 + 32'(i), 32'h4100 + 32'(i), 32'h4200 + 32'(i));
      iEnable = 1'b1;
      stepCycle();
    end
    iEnable = 1'b0;
    iReady  = 1'b1;
    stepCycle();
    iReady  = 1'b0;
    checkEq("mid_w1_data",  oData, 32'h4100);
    checkEq("mid_w1_count", 32'(oCount), 32'd3);
    #1;
    reset_n = 1'b0;
    #1;
    checkEq("async_rst_valid",    32'(oValid),    32'd0);
    checkEq("async_rst_count",    32'(oCount),    32'd0);
    checkEq("async_rst_overflow", 32'(oOverflow), 32'd0);
    checkEq("async_rst_data",     oData,          32'h0);
    stepCycle();
    reset_n = 1'b1;
    iReady  = 1'b1;
    driveSample(32'h00A00113, 32'h11, 32'h22);
    iEnable = 1'b1;
    stepCycle();
    iEnable = 1'b0;
    checkEq("post_rst_bubble", 32'(oValid), 32'd0);
    stepCycle();
    checkEq("post_rst_w0_valid", 32'(oValid), 32'd1);
    checkEq("post_rst_w0_data",  oData, 32'h00A00113);
    stepCycle();
    checkEq("post_rst_w1_data",  oData, 32'h11);
    stepCycle();
    checkEq("post_rst_w2_data",  oData, 32'h22);
    stepCycle();
    checkIdle("post_rst_done");

    $display("End of test - %0d assertions evaluated, %0d failures", numAsserts, numFails);
    $finish;
  end

endmodule
